num_class_gen: RTL
==================

# num_class_gen

Sequential generator for the 5-bit number classes used in the practice designs: prime, even, multiple of 3, or all values. After a `start` pulse it scans candidates 0..`MAX_VAL` in ascending order. Each member of the selected class is emitted on a valid/ready stream. This block is the reverse of the combinational number classifier: that block maps a number to class flags, and this one maps a class to its numbers. It feeds display and test-pattern logic in the practice top levels.

## Interface
- `MAX_VAL`, default 31: last candidate scanned, legal range 0..31.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begins a run. Sampled only in IDLE.
- `sel`  in  2  class select, captured with `start`: 00 prime, 01 even, 10 multiple of 3, 11 all.
- `out_data`  out  5  emitted class member.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts the value.
- `busy`  out  1  high in SCAN and HOLD.
- `done`  out  1  one-cycle pulse at the end of a run.

## Operation
- Registered FSM with four states: IDLE, SCAN, HOLD, DONE.
- **IDLE:**
  - When `start`=1: capture `sel` into `sel_q`, set `idx`=0, go to SCAN.
  - Otherwise remain in IDLE.
- **SCAN:** each cycle, classify `idx` under `sel_q`.
  - Match: `out_data`←`idx`, `out_valid`←1, go to HOLD.
  - No match and `idx`==`MAX_VAL`: go to DONE.
  - No match otherwise: `idx`←`idx`+1.
- **HOLD:**
  - `out_valid` and `out_data` stay stable until `out_valid`&`out_ready`.
  - On that handshake, `out_valid`←0.
  - If `out_data`==`MAX_VAL`, go to DONE. Otherwise `idx`←`idx`+1 and go to SCAN.
- **DONE:** `done`=1 for this single cycle, then go to IDLE.
- **Class definitions** (over 0..31):
  - prime = bit `v` of 32'hA08A28AC; this set is 2,3,5,7,11,13,17,19,23,29,31. 0 and 1 are not prime.
  - even = `v[0]`==0; this includes 0.
  - multiple of 3 = 0,3,...,30; this includes 0.
  - all = every value.
- **Counter width:** `idx` is 5 bits. It never increments past `MAX_VAL`, so no wrap occurs within a run.
- **Boundary conditions:**
  - `start` outside IDLE is ignored. `sel` changes after capture are ignored.
  - A class with no member ≤`MAX_VAL` (e.g. prime with `MAX_VAL`=1) emits nothing. `done` pulses after the scan completes.
  - `out_ready` high while `out_valid`=0 has no effect.
  - `rst` mid-run aborts the run immediately: state IDLE, no `done` pulse.
- **Reset values:**
  - state IDLE, `idx`=0, `sel_q`=0.
  - `out_data`=0, `out_valid`=0, `busy`=0, `done`=0.

## Timing
- All outputs are registered.
- Start edge E0, no backpressure: the first member `v` shows `out_valid`=1 after edge E(`v`+1). Example: prime run → `out_data`=2 after E3.
- Each scanned non-member costs 1 cycle.
- Each emitted member costs at least 2 cycles: the SCAN match plus the HOLD handshake. The next candidate is examined in the cycle after the handshake.
- `done` is high in the cycle after the final handshake or the final non-matching scan. IDLE follows one cycle later.
- Back-to-back runs: `start` is accepted in the IDLE cycle directly after DONE.

## Configuration
- `NUM_CLASS_GEN_COUNT_EN` defined:
  - Adds output `count[5:0]`: number of handshakes completed in the current run.
  - Cleared to 0 on an accepted `start` and on `rst`. Increments on each handshake. Holds its value after `done` until the next `start`.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package `num_class_pkg` holds:
  - `sel` encodings `CLS_PRIME`, `CLS_EVEN`, `CLS_MUL3`, `CLS_ALL`.
  - The state enum `gen_state_t`.
  - `PRIME_MASK` = 32'hA08A28AC.
- One sub-module, `num_class_match`: combinational, with inputs `v[4:0]` and `sel[1:0]` and output `match`. It is verifiable on its own against the class definitions above.

## Test plan
- Prime, `MAX_VAL`=31, `out_ready`=1 → outputs 2,3,5,7,11,13,17,19,23,29,31 in order. `done` pulses once. Count=11 when enabled.
- Multiple of 3 with random `out_ready` stalls → 0,3,...,30. `out_data` is stable during every stall, with no duplicates or drops. Count=11.
- Even, `MAX_VAL`=7 → 0,2,4,6. `done` follows the final non-matching scan of 7.
- Prime, `MAX_VAL`=1 → no `out_valid`. `done` pulses 2 cycles after the start edge.
- All: `start` pulsed again mid-run and `sel` toggled → sequence 0..31 unaffected.
- `rst` asserted while in HOLD on value 9 → next cycle all outputs are at reset values and no `done` pulse. A fresh `start` restarts from 0.

Source files
------------

// File: rtl/num_class_pkg.sv
// Shared encodings for the number-class generator: class selects, FSM states, prime lookup mask.
package num_class_pkg;

   localparam logic [1:0] CLS_PRIME = 2'b00;
   localparam logic [1:0] CLS_EVEN  = 2'b01;
   localparam logic [1:0] CLS_MUL3  = 2'b10;
   localparam logic [1:0] CLS_ALL   = 2'b11;

   // Bit v set when v is prime, for v in 0..31.
   localparam logic [31:0] PRIME_MASK = 32'hA08A28AC;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_HOLD = 2'd2,
      ST_DONE = 2'd3
   } gen_state_t;

endpackage

// File: rtl/num_class_match.sv
// Combinational class membership test for a 5-bit value under a 2-bit class select.
module num_class_match
   import num_class_pkg::*;
(
   input  logic [4:0] v,
   input  logic [1:0] sel,
   output logic       match
);

   always_comb begin
      match = 1'b0;
      case (sel)
         CLS_PRIME: match = PRIME_MASK[v];
         CLS_EVEN:  match = ~v[0];
         CLS_MUL3:  match = ((v % 5'd3) == 5'd0);
         default:   match = 1'b1;
      endcase
   end

endmodule

// File: rtl/num_class_gen.sv
// Scans 0..MAX_VAL after start and streams each member of the selected class on valid/ready.
// Optional handshake counter output enabled by NUM_CLASS_GEN_COUNT_EN.
module num_class_gen
   import num_class_pkg::*;
#(
   parameter int unsigned MAX_VAL = 31
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] sel,
   output logic [4:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       busy,
`ifdef NUM_CLASS_GEN_COUNT_EN
   output logic [5:0] count,
`endif
   output logic       done
);

   localparam logic [4:0] MAX_V = 5'(MAX_VAL);

   gen_state_t state_q, state_d;
   logic [4:0] idx_q, idx_d;
   logic [1:0] sel_q, sel_d;
   logic [4:0] data_q, data_d;
   logic       vld_q, vld_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic [5:0] cnt_q, cnt_d;
   logic       match;
   logic       hshake;

   num_class_match u_match (
      .v     (idx_q),
      .sel   (sel_q),
      .match (match)
   );

   assign hshake = vld_q & out_ready;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      sel_d   = sel_q;
      data_d  = data_q;
      vld_d   = vld_q;
      done_d  = 1'b0;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               sel_d   = sel;
               idx_d   = 5'd0;
               cnt_d   = 6'd0;
               state_d = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (match) begin
               data_d  = idx_q;
               vld_d   = 1'b1;
               state_d = ST_HOLD;
            end else if (idx_q == MAX_V) begin
               done_d  = 1'b1;
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + 5'd1;
            end
         end
         ST_HOLD: begin
            if (hshake) begin
               vld_d = 1'b0;
               cnt_d = cnt_q + 6'd1;
               // idx only advances below MAX_V, so it never wraps inside a run.
               if (data_q == MAX_V) begin
                  done_d  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  idx_d   = idx_q + 5'd1;
                  state_d = ST_SCAN;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_SCAN) || (state_d == ST_HOLD);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= 5'd0;
         sel_q   <= 2'd0;
         data_q  <= 5'd0;
         vld_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= 6'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         sel_q   <= sel_d;
         data_q  <= data_d;
         vld_q   <= vld_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out_data  = data_q;
   assign out_valid = vld_q;
   assign busy      = busy_q;
   assign done      = done_q;
`ifdef NUM_CLASS_GEN_COUNT_EN
   assign count     = cnt_q;
`else
   logic unused_cnt;
   assign unused_cnt = ^cnt_q;
`endif

endmodule
